// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: byte-wide RAM/IO bus plus the fetcher and load/store-buffer request channels
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  rdy;
  logic                  io_buffer_full;
  logic [7:0]            ram_data_in;
  logic [7:0]            ram_data_out;
  logic [ADDR_WIDTH-1:0] ram_address_out;
  logic                  ram_rw_signal_out;
  logic                  rollback_in;
  logic                  fet_request_in;
  logic [ADDR_WIDTH-1:0] fet_address_in;
  logic                  fet_ready_out;
  logic [31:0]           fet_instruction_out;
  logic                  lsb_request_in;
  logic                  lsb_rw_signal_in;
  logic [ADDR_WIDTH-1:0] lsb_address_in;
  logic [2:0]            lsb_goal_in;
  logic [31:0]           lsb_data_in;
  logic                  lsb_ready_out;
  logic [31:0]           lsb_data_out;
  modport slave (
    input  rdy, io_buffer_full, ram_data_in, rollback_in,
           fet_request_in, fet_address_in,
           lsb_request_in, lsb_rw_signal_in, lsb_address_in, lsb_goal_in, lsb_data_in,
    output ram_data_out, ram_address_out, ram_rw_signal_out,
           fet_ready_out, fet_instruction_out, lsb_ready_out, lsb_data_out
  );
  modport master (
    output rdy, io_buffer_full, ram_data_in, rollback_in,
           fet_request_in, fet_address_in,
           lsb_request_in, lsb_rw_signal_in, lsb_address_in, lsb_goal_in, lsb_data_in,
    input  ram_data_out, ram_address_out, ram_rw_signal_out,
           fet_ready_out, fet_instruction_out, lsb_ready_out, lsb_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the byte-wide RAM/IO bus to fetcher or LSB and serialises accesses into byte cycles
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_WIDTH   = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [1:0]            r_state;
  logic [2:0]            r_k;
  logic [2:0]            r_n;
  logic                  r_owner;
  logic                  r_store;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic [31:0]           r_fet_out;
  logic [31:0]           r_lsb_out;
  logic [SW-1:0]         r_starve;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_byte;
  logic [1:0]            w_km1;
  logic [31:0]           w_cap;
  logic                  w_io_stall;
  logic                  w_idle_ok;
  logic                  w_grant_fet;
  logic                  w_grant_lsb;
  assign w_addr      = r_base + ADDR_WIDTH'(r_k);
  assign w_byte      = 8'(r_wdata >> {r_k[1:0], 3'b000});
  assign w_km1       = r_k[1:0] - 2'd1;
  assign w_cap       = (r_buf & ~(32'hFF << {w_km1, 3'b000})) | ({24'h0, bus.ram_data_in} << {w_km1, 3'b000});
  assign w_io_stall  = (w_addr[17:16] == 2'b11) && bus.io_buffer_full;
  assign w_idle_ok   = (r_state == IDLE) && !bus.rollback_in;
  assign w_grant_fet = w_idle_ok && bus.fet_request_in && (!bus.lsb_request_in || r_starve == STARVE_MAX);
  assign w_grant_lsb = w_idle_ok && bus.lsb_request_in && !w_grant_fet;
  assign bus.ram_address_out     = ((r_state == READ && r_k < r_n) || r_state == WRITE) ? w_addr : '0;
  assign bus.ram_data_out        = (r_state == WRITE) ? w_byte : 8'h00;
  assign bus.ram_rw_signal_out   = (r_state == WRITE) && bus.rdy && !w_io_stall;
  assign bus.fet_ready_out       = (r_state == DONE) && bus.rdy && !r_owner && !bus.rollback_in;
  assign bus.lsb_ready_out       = (r_state == DONE) && bus.rdy && r_owner && (r_store || !bus.rollback_in);
  assign bus.fet_instruction_out = r_fet_out;
  assign bus.lsb_data_out        = r_lsb_out;
  // arbitrate in IDLE, walk bytes in READ/WRITE, hold DONE one cycle; rdy low freezes everything
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_n       <= '0;
      r_owner   <= 1'b0;
      r_store   <= 1'b0;
      r_base    <= '0;
      r_wdata   <= '0;
      r_buf     <= '0;
      r_fet_out <= '0;
      r_lsb_out <= '0;
      r_starve  <= '0;
    end else if (bus.rdy) begin
      case (r_state)
        IDLE: begin
          r_k   <= '0;
          r_buf <= '0;
          if (w_grant_fet) begin
            r_state  <= READ;
            r_owner  <= 1'b0;
            r_store  <= 1'b0;
            r_base   <= bus.fet_address_in;
            r_n      <= 3'd4;
            r_starve <= '0;
          end else if (w_grant_lsb) begin
            r_state <= bus.lsb_rw_signal_in ? WRITE : READ;
            r_owner <= 1'b1;
            r_store <= bus.lsb_rw_signal_in;
            r_base  <= bus.lsb_address_in;
            r_n     <= bus.lsb_goal_in;
            r_wdata <= bus.lsb_data_in;
            if (bus.fet_request_in && r_starve != STARVE_MAX) r_starve <= r_starve + 1'b1;
          end
        end
        READ:
          if (bus.rollback_in) r_state <= IDLE;
          else begin
            r_k <= r_k + 3'd1;
            if (r_k != 3'd0) r_buf <= w_cap;
            if (r_k == r_n) begin
              r_state <= DONE;
              if (r_owner) r_lsb_out <= w_cap;
              else r_fet_out <= w_cap;
            end
          end
        WRITE:
          if (!w_io_stall) begin
            r_k <= r_k + 3'd1;
            if (r_k + 3'd1 == r_n) r_state <= DONE;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench driving fetch/LSB traffic against a byte memory model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0]  mem [logic [31:0]];
  logic [39:0] wr_log [$];
  logic [31:0] q_fet [$];
  logic [31:0] q_lsb [$];
  logic [39:0] q_wr [$];
  logic        q_seq [$];

  mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus ();
  mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // byte memory: read data registered one cycle after its address, every committed write logged
  always @(posedge clk) begin
    bus.ram_data_in <= mem.exists(bus.ram_address_out) ? mem[bus.ram_address_out] : 8'h00;
    if (bus.ram_rw_signal_out) wr_log.push_back({bus.ram_address_out, bus.ram_data_out});
  end

  task automatic idle_inputs();
    bus.rdy = 1'b1;
    bus.io_buffer_full = 1'b0;
    bus.rollback_in = 1'b0;
    bus.fet_request_in = 1'b0;
    bus.fet_address_in = '0;
    bus.lsb_request_in = 1'b0;
    bus.lsb_rw_signal_in = 1'b0;
    bus.lsb_address_in = '0;
    bus.lsb_goal_in = '0;
    bus.lsb_data_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wr_log.delete();
    q_fet.delete();
    q_lsb.delete();
    q_wr.delete();
    q_seq.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    n_tests++; if (bus.ram_address_out !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want %h", bus.ram_address_out, 32'h0); end
    n_tests++; if (bus.ram_rw_signal_out !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b want 0", bus.ram_rw_signal_out); end
    n_tests++; if (bus.ram_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", bus.ram_data_out); end
    n_tests++; if ({bus.fet_ready_out, bus.lsb_ready_out} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {bus.fet_ready_out, bus.lsb_ready_out}); end
    n_tests++; if ({bus.fet_instruction_out, bus.lsb_data_out} !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {bus.fet_instruction_out, bus.lsb_data_out}); end
  endtask

  task automatic test_fetch();
    logic [31:0] exp;
    do_reset();
    q_fet.push_back(32'h93000013);
    bus.fet_request_in = 1'b1;
    bus.fet_address_in = 32'h100;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        n_tests++; if (bus.ram_address_out !== 32'h100 + c - 1) begin n_fail++; $display("FAIL fetch_addr c%0d: got %h want %h", c, bus.ram_address_out, 32'h100 + c - 1); end
      end
      n_tests++; if (bus.fet_ready_out !== (c == 6)) begin n_fail++; $display("FAIL fetch_ready c%0d: got %b want %b", c, bus.fet_ready_out, c == 6); end
      if (bus.fet_ready_out && q_fet.size() > 0) begin
        exp = q_fet.pop_front();
        n_tests++; if (bus.fet_instruction_out !== exp) begin n_fail++; $display("FAIL fetch_data: got %h want %h", bus.fet_instruction_out, exp); end
      end
      @(posedge clk); #1;
      if (c == 6) bus.fet_request_in = 1'b0;
    end
  endtask

  task automatic test_priority();
    logic [31:0] exp;
    do_reset();
    q_lsb.push_back(32'h000000FF);
    q_fet.push_back(32'h93000013);
    bus.fet_request_in = 1'b1;
    bus.fet_address_in = 32'h100;
    bus.lsb_request_in = 1'b1;
    bus.lsb_address_in = 32'h200;
    bus.lsb_goal_in = 3'd1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_tests++; if (bus.lsb_ready_out !== (c == 3)) begin n_fail++; $display("FAIL prio_lsb_ready c%0d: got %b want %b", c, bus.lsb_ready_out, c == 3); end
      n_tests++; if (bus.fet_ready_out !== (c == 10)) begin n_fail++; $display("FAIL prio_fet_ready c%0d: got %b want %b", c, bus.fet_ready_out, c == 10); end
      if (c == 1) begin
        n_tests++; if (bus.ram_address_out !== 32'h200) begin n_fail++; $display("FAIL prio_lsb_addr: got %h want 00000200", bus.ram_address_out); end
      end
      if (c == 5) begin
        n_tests++; if (bus.ram_address_out !== 32'h100) begin n_fail++; $display("FAIL prio_fet_addr: got %h want 00000100", bus.ram_address_out); end
      end
      if (bus.lsb_ready_out && q_lsb.size() > 0) begin
        exp = q_lsb.pop_front();
        n_tests++; if (bus.lsb_data_out !== exp) begin n_fail++; $display("FAIL prio_lsb_data: got %h want %h", bus.lsb_data_out, exp); end
      end
      if (bus.fet_ready_out && q_fet.size() > 0) begin
        exp = q_fet.pop_front();
        n_tests++; if (bus.fet_instruction_out !== exp) begin n_fail++; $display("FAIL prio_fet_data: got %h want %h", bus.fet_instruction_out, exp); end
      end
      @(posedge clk); #1;
      if (c == 3) bus.lsb_request_in = 1'b0;
      if (c == 10) bus.fet_request_in = 1'b0;
    end
  endtask

  task automatic test_starve();
    logic [31:0] exp;
    logic        exp_lsb;
    logic        was_lsb;
    int          events;
    int          li;
    do_reset();
    for (int i = 0; i < 5; i++) q_lsb.push_back(32'h10 + i);
    q_fet.push_back(32'h93000013);
    q_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    events = 0;
    li = 0;
    bus.fet_request_in = 1'b1;
    bus.fet_address_in = 32'h100;
    bus.lsb_request_in = 1'b1;
    bus.lsb_address_in = 32'h210;
    bus.lsb_goal_in = 3'd1;
    for (int c = 0; c < 60 && events < 6; c++) begin
      @(negedge clk);
      was_lsb = bus.lsb_ready_out;
      if ((bus.lsb_ready_out || bus.fet_ready_out) && q_seq.size() > 0) begin
        exp_lsb = q_seq.pop_front();
        n_tests++; if (bus.lsb_ready_out !== exp_lsb) begin n_fail++; $display("FAIL starve_order ev%0d: got lsb=%b want lsb=%b", events, bus.lsb_ready_out, exp_lsb); end
        if (bus.lsb_ready_out && q_lsb.size() > 0) begin
          exp = q_lsb.pop_front();
          n_tests++; if (bus.lsb_data_out !== exp) begin n_fail++; $display("FAIL starve_lsb_data ev%0d: got %h want %h", events, bus.lsb_data_out, exp); end
        end
        if (bus.fet_ready_out && q_fet.size() > 0) begin
          exp = q_fet.pop_front();
          n_tests++; if (bus.fet_instruction_out !== exp) begin n_fail++; $display("FAIL starve_fet_data: got %h want %h", bus.fet_instruction_out, exp); end
        end
        events++;
      end
      @(posedge clk); #1;
      if (was_lsb) begin
        li++;
        bus.lsb_address_in = 32'h210 + li;
      end
    end
    n_tests++; if (events !== 6) begin n_fail++; $display("FAIL starve_timeout: got %0d events want 6", events); end
    bus.fet_request_in = 1'b0;
    bus.lsb_request_in = 1'b0;
  endtask

  task automatic test_io_stall();
    logic [39:0] exp;
    do_reset();
    q_wr.push_back({32'h30000, 8'h41});
    bus.lsb_request_in = 1'b1;
    bus.lsb_rw_signal_in = 1'b1;
    bus.lsb_address_in = 32'h30000;
    bus.lsb_goal_in = 3'd1;
    bus.lsb_data_in = 32'h41;
    bus.io_buffer_full = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        n_tests++; if (bus.ram_address_out !== 32'h30000) begin n_fail++; $display("FAIL io_addr c%0d: got %h want 00030000", c, bus.ram_address_out); end
      end
      n_tests++; if (bus.ram_rw_signal_out !== (c == 4)) begin n_fail++; $display("FAIL io_rw c%0d: got %b want %b", c, bus.ram_rw_signal_out, c == 4); end
      if (c == 4) begin
        n_tests++; if (bus.ram_data_out !== 8'h41) begin n_fail++; $display("FAIL io_dout: got %h want 41", bus.ram_data_out); end
      end
      n_tests++; if (bus.lsb_ready_out !== (c == 5)) begin n_fail++; $display("FAIL io_ready c%0d: got %b want %b", c, bus.lsb_ready_out, c == 5); end
      @(posedge clk); #1;
      if (c == 3) bus.io_buffer_full = 1'b0;
      if (c == 5) bus.lsb_request_in = 1'b0;
    end
    n_tests++; if (wr_log.size() !== 1) begin n_fail++; $display("FAIL io_wr_count: got %0d want 1", wr_log.size()); end
    if (wr_log.size() > 0 && q_wr.size() > 0) begin
      exp = q_wr.pop_front();
      n_tests++; if (wr_log[0] !== exp) begin n_fail++; $display("FAIL io_wr_entry: got %h want %h", wr_log[0], exp); end
    end
  endtask

  task automatic test_rollback();
    logic [31:0] exp;
    do_reset();
    bus.fet_request_in = 1'b1;
    bus.fet_address_in = 32'h100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++; if (bus.fet_ready_out !== 1'b0) begin n_fail++; $display("FAIL rb_fet_ready c%0d: got %b want 0", c, bus.fet_ready_out); end
      if (c == 4) begin
        n_tests++; if ({bus.ram_address_out, bus.ram_rw_signal_out} !== 33'h0) begin n_fail++; $display("FAIL rb_idle: got addr=%h rw=%b want 0", bus.ram_address_out, bus.ram_rw_signal_out); end
      end
      @(posedge clk); #1;
      bus.rollback_in = (c == 2);
      if (c == 3) bus.fet_request_in = 1'b0;
    end
    q_fet.push_back(32'h93000013);
    bus.rollback_in = 1'b1;
    bus.fet_request_in = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_tests++; if (bus.ram_address_out !== 32'h0) begin n_fail++; $display("FAIL rb_no_grant: got %h want 00000000", bus.ram_address_out); end
      end
      if (c == 2) begin
        n_tests++; if (bus.ram_address_out !== 32'h100) begin n_fail++; $display("FAIL rb_late_grant: got %h want 00000100", bus.ram_address_out); end
      end
      n_tests++; if (bus.fet_ready_out !== (c == 7)) begin n_fail++; $display("FAIL rb_late_ready c%0d: got %b want %b", c, bus.fet_ready_out, c == 7); end
      if (bus.fet_ready_out && q_fet.size() > 0) begin
        exp = q_fet.pop_front();
        n_tests++; if (bus.fet_instruction_out !== exp) begin n_fail++; $display("FAIL rb_late_data: got %h want %h", bus.fet_instruction_out, exp); end
      end
      @(posedge clk); #1;
      bus.rollback_in = 1'b0;
      if (c == 7) bus.fet_request_in = 1'b0;
    end
  endtask

  task automatic test_store_rollback();
    logic [39:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) q_wr.push_back({32'h400 + i, 8'hAA + 8'(i * 8'h11)});
    bus.lsb_request_in = 1'b1;
    bus.lsb_rw_signal_in = 1'b1;
    bus.lsb_address_in = 32'h400;
    bus.lsb_goal_in = 3'd4;
    bus.lsb_data_in = 32'hDDCCBBAA;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_tests++; if (bus.lsb_ready_out !== (c == 5)) begin n_fail++; $display("FAIL st_rb_ready c%0d: got %b want %b", c, bus.lsb_ready_out, c == 5); end
      @(posedge clk); #1;
      bus.rollback_in = (c == 1 || c == 4);
      if (c == 5) bus.lsb_request_in = 1'b0;
    end
    n_tests++; if (wr_log.size() !== 4) begin n_fail++; $display("FAIL st_rb_count: got %0d want 4", wr_log.size()); end
    for (int i = 0; i < wr_log.size() && q_wr.size() > 0; i++) begin
      exp = q_wr.pop_front();
      n_tests++; if (wr_log[i] !== exp) begin n_fail++; $display("FAIL st_rb_byte%0d: got %h want %h", i, wr_log[i], exp); end
    end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] exp;
    do_reset();
    q_lsb.push_back(32'h44332211);
    bus.lsb_request_in = 1'b1;
    bus.lsb_address_in = 32'h500;
    bus.lsb_goal_in = 3'd4;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 5) begin
        n_tests++; if ({bus.ram_address_out, bus.ram_rw_signal_out} !== {32'h500, 1'b0}) begin n_fail++; $display("FAIL frz_hold c%0d: got addr=%h rw=%b want 00000500/0", c, bus.ram_address_out, bus.ram_rw_signal_out); end
      end
      n_tests++; if (bus.lsb_ready_out !== (c == 11)) begin n_fail++; $display("FAIL frz_ready c%0d: got %b want %b", c, bus.lsb_ready_out, c == 11); end
      if (bus.lsb_ready_out && q_lsb.size() > 0) begin
        exp = q_lsb.pop_front();
        n_tests++; if (bus.lsb_data_out !== exp) begin n_fail++; $display("FAIL frz_data: got %h want %h", bus.lsb_data_out, exp); end
      end
      @(posedge clk); #1;
      bus.rdy = (c >= 5);
      if (c == 11) bus.lsb_request_in = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [39:0] exp;
    do_reset();
    q_wr.push_back({32'h600, 8'hAA});
    q_wr.push_back({32'h601, 8'hBB});
    bus.lsb_request_in = 1'b1;
    bus.lsb_rw_signal_in = 1'b1;
    bus.lsb_address_in = 32'h600;
    bus.lsb_goal_in = 3'd4;
    bus.lsb_data_in = 32'hDDCCBBAA;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        n_tests++; if ({bus.ram_address_out, bus.ram_rw_signal_out} !== {32'h601, 1'b0}) begin n_fail++; $display("FAIL ar_frozen_wr: got addr=%h rw=%b want 00000601/0", bus.ram_address_out, bus.ram_rw_signal_out); end
      end
      if (c == 3) begin
        n_tests++; if (bus.ram_rw_signal_out !== 1'b1) begin n_fail++; $display("FAIL ar_resume_wr: got %b want 1", bus.ram_rw_signal_out); end
      end
      @(posedge clk); #1;
      bus.rdy = (c != 1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if ({bus.ram_address_out, bus.ram_data_out, bus.ram_rw_signal_out, bus.lsb_ready_out} !== 42'h0) begin n_fail++; $display("FAIL ar_outputs: got addr=%h dout=%h rw=%b rdy=%b want 0", bus.ram_address_out, bus.ram_data_out, bus.ram_rw_signal_out, bus.lsb_ready_out); end
    bus.lsb_request_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++; if ({bus.ram_rw_signal_out, bus.lsb_ready_out} !== 2'b00) begin n_fail++; $display("FAIL ar_quiet c%0d: got rw/rdy=%b want 00", c, {bus.ram_rw_signal_out, bus.lsb_ready_out}); end
    end
    n_tests++; if (wr_log.size() !== 2) begin n_fail++; $display("FAIL ar_wr_count: got %0d want 2", wr_log.size()); end
    for (int i = 0; i < wr_log.size() && q_wr.size() > 0; i++) begin
      exp = q_wr.pop_front();
      n_tests++; if (wr_log[i] !== exp) begin n_fail++; $display("FAIL ar_byte%0d: got %h want %h", i, wr_log[i], exp); end
    end
  endtask

  initial begin
    mem[32'h100] = 8'h13;
    mem[32'h101] = 8'h00;
    mem[32'h102] = 8'h00;
    mem[32'h103] = 8'h93;
    mem[32'h200] = 8'hFF;
    for (int i = 0; i < 5; i++) mem[32'h210 + i] = 8'(8'h10 + i);
    mem[32'h500] = 8'h11;
    mem[32'h501] = 8'h22;
    mem[32'h502] = 8'h33;
    mem[32'h503] = 8'h44;
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_io_stall();
    test_rollback();
    test_store_rollback();
    test_rdy_freeze();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
